// File: rtl/usb_nrzi_tx.sv
// USB line transmit stage: bit stuffing, NRZI encoding and EOP generation onto registered dp/dm.
// Define USB_LOW_SPEED_EN to select low-speed polarity (J = dp 0 / dm 1); the default is full-speed.
module usb_nrzi_tx #(
   parameter int MAX_ONES     = 6,
   parameter int EOP_SE0_BITS = 2
) (
   input  logic clk,
   input  logic rst_b,
   input  logic bit_in,
   input  logic bit_valid,
   output logic stall,
   output logic dp,
   output logic dm,
   output logic tx_active,
   output logic eop_done
);

   localparam int OW = $clog2(MAX_ONES + 1);
   localparam int EW = $clog2(EOP_SE0_BITS + 1);

`ifdef USB_LOW_SPEED_EN
   localparam logic J_DP = 1'b0;
`else
   localparam logic J_DP = 1'b1;
`endif

   localparam logic [1:0] LINE_SE0 = 2'b00;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_STUFF,
      S_EOP_SE0,
      S_EOP_J
   } state_t;

   state_t          r_state;
   logic            r_level;
   logic [OW-1:0]   r_ones;
   logic [EW-1:0]   r_eop;
   logic            r_dp;
   logic            r_dm;
   logic            r_act;
   logic            r_eop_done;

   logic            w_level_nxt;
   logic [OW-1:0]   w_ones_nxt;
   logic            w_stuff_hit;

   // Level 1 is J, level 0 is K; polarity depends on bus speed.
   function automatic logic [1:0] line_of(input logic level);
      return level ? {J_DP, ~J_DP} : {~J_DP, J_DP};
   endfunction

   assign w_level_nxt = bit_in ? r_level : ~r_level;
   assign w_ones_nxt  = bit_in ? (r_ones + OW'(1)) : '0;
   assign w_stuff_hit = (w_ones_nxt == OW'(MAX_ONES));

   assign stall     = (r_state == S_STUFF) || (r_state == S_EOP_SE0) || (r_state == S_EOP_J);
   assign dp        = r_dp;
   assign dm        = r_dm;
   assign tx_active = r_act;
   assign eop_done  = r_eop_done;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         r_state      <= S_IDLE;
         r_level      <= 1'b1;
         r_ones       <= '0;
         r_eop        <= '0;
         {r_dp, r_dm} <= line_of(1'b1);
         r_act        <= 1'b0;
         r_eop_done   <= 1'b0;
      end else begin
         r_eop_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bit_valid) begin
                  r_level      <= w_level_nxt;
                  {r_dp, r_dm} <= line_of(w_level_nxt);
                  r_act        <= 1'b1;
                  r_ones       <= w_ones_nxt;
                  r_state      <= w_stuff_hit ? S_STUFF : S_SEND;
               end else begin
                  r_level      <= 1'b1;
                  {r_dp, r_dm} <= line_of(1'b1);
                  r_act        <= 1'b0;
                  r_ones       <= '0;
               end
            end
            S_SEND: begin
               if (bit_valid) begin
                  r_level      <= w_level_nxt;
                  {r_dp, r_dm} <= line_of(w_level_nxt);
                  r_ones       <= w_ones_nxt;
                  r_state      <= w_stuff_hit ? S_STUFF : S_SEND;
               end else begin
                  {r_dp, r_dm} <= LINE_SE0;
                  r_eop        <= EW'(1);
                  r_ones       <= '0;
                  r_state      <= S_EOP_SE0;
               end
            end
            // Stuffed 0: upstream is stalled, so bit_in is held for the next SEND cycle.
            S_STUFF: begin
               r_level      <= ~r_level;
               {r_dp, r_dm} <= line_of(~r_level);
               r_ones       <= '0;
               r_state      <= S_SEND;
            end
            S_EOP_SE0: begin
               if (r_eop < EW'(EOP_SE0_BITS)) begin
                  {r_dp, r_dm} <= LINE_SE0;
                  r_eop        <= r_eop + EW'(1);
               end else begin
                  r_level      <= 1'b1;
                  {r_dp, r_dm} <= line_of(1'b1);
                  r_eop        <= '0;
                  r_eop_done   <= 1'b1;
                  r_state      <= S_EOP_J;
               end
            end
            S_EOP_J: begin
               r_act   <= 1'b0;
               r_ones  <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_usb_nrzi_tx.sv
// Directed bench for usb_nrzi_tx: SYNC, stuffing, trailing stuff, back-to-back packets, async reset.
module tb_usb_nrzi_tx;

`ifdef USB_LOW_SPEED_EN
   localparam logic [1:0] LJ = 2'b01;
   localparam logic [1:0] LK = 2'b10;
`else
   localparam logic [1:0] LJ = 2'b10;
   localparam logic [1:0] LK = 2'b01;
`endif
   localparam logic [1:0] LS = 2'b00;

   logic clk = 1'b0;
   logic rst_b;
   logic bit_in;
   logic bit_valid;
   logic stall;
   logic dp;
   logic dm;
   logic tx_active;
   logic eop_done;

   int n_total = 0;
   int n_bad   = 0;

   usb_nrzi_tx #(.MAX_ONES(6), .EOP_SE0_BITS(2)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .bit_in    (bit_in),
      .bit_valid (bit_valid),
      .stall     (stall),
      .dp        (dp),
      .dm        (dm),
      .tx_active (tx_active),
      .eop_done  (eop_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of input, clock it, then check the registered/derived outputs.
   task automatic tick(input string tag, input logic v, input logic b, input logic [1:0] line,
                       input logic st, input logic act, input logic eop);
      bit_valid = v;
      bit_in    = b;
      @(posedge clk);
      #1;
      chk({tag, ".line"}, {6'd0, dp, dm}, {6'd0, line});
      chk({tag, ".stall"}, {7'd0, stall}, {7'd0, st});
      chk({tag, ".act"}, {7'd0, tx_active}, {7'd0, act});
      chk({tag, ".eop"}, {7'd0, eop_done}, {7'd0, eop});
   endtask

   initial begin
      logic [7:0] sync_bits;
      logic [1:0] sync_line [8];
      sync_bits = 8'b1000_0000;
      sync_line = '{LK, LJ, LK, LJ, LK, LJ, LK, LK};

      rst_b     = 1'b0;
      bit_valid = 1'b0;
      bit_in    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.line", {6'd0, dp, dm}, {6'd0, LJ});
      chk("rst.stall", {7'd0, stall}, 8'd0);
      chk("rst.act", {7'd0, tx_active}, 8'd0);
      chk("rst.eop", {7'd0, eop_done}, 8'd0);
      #2 rst_b = 1'b1;
      tick("idle", 1'b0, 1'b0, LJ, 1'b0, 1'b0, 1'b0);

      // SYNC pattern then EOP
      for (int i = 0; i < 8; i++)
         tick($sformatf("sync%0d", i), 1'b1, sync_bits[i], sync_line[i], 1'b0, 1'b1, 1'b0);
      tick("sync.se0a", 1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("sync.se0b", 1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("sync.j",    1'b0, 1'b0, LJ, 1'b1, 1'b1, 1'b1);
      tick("sync.idle", 1'b0, 1'b0, LJ, 1'b0, 1'b0, 1'b0);

      // Eight 1s mid-packet from level J; 7th 1 is held through the stall
      tick("run.b0", 1'b1, 1'b0, LK, 1'b0, 1'b1, 1'b0);
      tick("run.b1", 1'b1, 1'b0, LJ, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++)
         tick($sformatf("run.one%0d", i), 1'b1, 1'b1, LJ, 1'b0, 1'b1, 1'b0);
      tick("run.one6",  1'b1, 1'b1, LJ, 1'b1, 1'b1, 1'b0);
      tick("run.stuff", 1'b1, 1'b1, LK, 1'b0, 1'b1, 1'b0);
      tick("run.one7",  1'b1, 1'b1, LK, 1'b0, 1'b1, 1'b0);
      tick("run.one8",  1'b1, 1'b1, LK, 1'b0, 1'b1, 1'b0);
      tick("run.se0a",  1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("run.se0b",  1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("run.j",     1'b0, 1'b0, LJ, 1'b1, 1'b1, 1'b1);
      tick("run.idle",  1'b0, 1'b0, LJ, 1'b0, 1'b0, 1'b0);

      // Packet of exactly six 1s: stuff bit precedes EOP
      for (int i = 1; i <= 5; i++)
         tick($sformatf("tail.one%0d", i), 1'b1, 1'b1, LJ, 1'b0, 1'b1, 1'b0);
      tick("tail.one6",  1'b1, 1'b1, LJ, 1'b1, 1'b1, 1'b0);
      tick("tail.stuff", 1'b0, 1'b0, LK, 1'b0, 1'b1, 1'b0);
      tick("tail.se0a",  1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("tail.se0b",  1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("tail.j",     1'b0, 1'b0, LJ, 1'b1, 1'b1, 1'b1);
      tick("tail.idle",  1'b0, 1'b0, LJ, 1'b0, 1'b0, 1'b0);

      // One-bit packet A, packet B's first bit pending through EOP
      tick("bb.a0",   1'b1, 1'b0, LK, 1'b0, 1'b1, 1'b0);
      tick("bb.se0a", 1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("bb.se0b", 1'b1, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("bb.j",    1'b1, 1'b0, LJ, 1'b1, 1'b1, 1'b1);
      tick("bb.gap",  1'b1, 1'b0, LJ, 1'b0, 1'b0, 1'b0);
      tick("bb.b0",   1'b1, 1'b0, LK, 1'b0, 1'b1, 1'b0);
      tick("bb.b1",   1'b1, 1'b1, LK, 1'b0, 1'b1, 1'b0);
      tick("bb.se0c", 1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("bb.se0d", 1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("bb.j2",   1'b0, 1'b0, LJ, 1'b1, 1'b1, 1'b1);
      tick("bb.idle", 1'b0, 1'b0, LJ, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset during SE0, then a fresh packet from level J
      tick("ar.b0",  1'b1, 1'b0, LK, 1'b0, 1'b1, 1'b0);
      tick("ar.se0", 1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      #2 rst_b = 1'b0;
      #1;
      chk("ar.line", {6'd0, dp, dm}, {6'd0, LJ});
      chk("ar.act", {7'd0, tx_active}, 8'd0);
      chk("ar.stall", {7'd0, stall}, 8'd0);
      chk("ar.eop", {7'd0, eop_done}, 8'd0);
      #1 rst_b = 1'b1;
      tick("ar.n0",   1'b1, 1'b0, LK, 1'b0, 1'b1, 1'b0);
      tick("ar.n1",   1'b1, 1'b1, LK, 1'b0, 1'b1, 1'b0);
      tick("ar.se0a", 1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("ar.se0b", 1'b0, 1'b0, LS, 1'b1, 1'b1, 1'b0);
      tick("ar.j",    1'b0, 1'b0, LJ, 1'b1, 1'b1, 1'b1);
      tick("ar.idle", 1'b0, 1'b0, LJ, 1'b0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/usb_nrzi_tx.md
Name: usb_nrzi_tx

Overview:
- Line-side transmit stage directly downstream of the packet/CRC serializer.
- Consumes a serial bit stream in transmit order (SYNC, PID, payload, CRC, LSB-first per field).
- Applies USB bit stuffing and NRZI encoding, appends EOP (SE0 x2, then J), and drives registered dp/dm.
- Back-pressures the serializer with `stall` while inserting stuff bits or generating EOP.

Parameters:
- MAX_ONES, 6: consecutive 1s that force a stuffed 0.
- EOP_SE0_BITS, 2: SE0 bit times in EOP.

Ports:
- clk  in  1  bit-rate clock, one bit time per cycle
- rst_b  in  1  asynchronous active-low reset
- bit_in  in  1  next unencoded bit
- bit_valid  in  1  bit_in valid; held high for the whole packet, low marks end of packet
- stall  out  1  bit_in not consumed this cycle; upstream holds bit_in
- dp  out  1  D+ line level, registered
- dm  out  1  D- line level, registered
- tx_active  out  1  line driven with packet/EOP, registered
- eop_done  out  1  one-cycle pulse; EOP J is on the line

Behaviour:
- Clock and reset: single clock `clk`; reset `rst_b` is asynchronous and active-low.
- Reset, and asynchronously mid-packet:
  - state=IDLE, level=1, ones_cnt=0, eop_cnt=0.
  - dp=1, dm=0 (J), tx_active=0, stall=0, eop_done=0.
- Line encoding: level 1 = J (dp=1, dm=0); level 0 = K (dp=0, dm=1); SE0 = dp=0, dm=0.
- NRZI: a 0 bit toggles level; a 1 bit holds level.
- Handshake:
  - A bit is consumed when bit_valid && !stall.
  - stall = (state is STUFF, EOP_SE0 or EOP_J), combinational from state.
  - Upstream must keep bit_in stable while stalled.
- Latency: a bit consumed in cycle t appears on dp/dm in cycle t+1, for exactly one cycle.
- ones_cnt: counts consecutive consumed 1s, width clog2(MAX_ONES+1). Cleared on a consumed 0, a stuff bit, and in IDLE/EOP states.
- FSM; each state defines the next values of the registers:
  - IDLE:
    - bit_valid=1: encode bit, tx_active<=1, update ones_cnt. Go to STUFF if ones_cnt reaches MAX_ONES, else SEND.
    - bit_valid=0: drive J, tx_active<=0.
  - SEND:
    - bit_valid=1: encode bit, update ones_cnt. Go to STUFF if ones_cnt==MAX_ONES, else stay in SEND.
    - bit_valid=0: drive SE0, eop_cnt<=1, go to EOP_SE0.
  - STUFF: toggle level (stuffed 0), ones_cnt<=0, go to SEND. A trailing run of MAX_ONES 1s is therefore always stuffed before EOP.
  - EOP_SE0:
    - eop_cnt<EOP_SE0_BITS: drive SE0, eop_cnt++.
    - Otherwise: level<=1, drive J, go to EOP_J.
  - EOP_J: eop_done=1, go to IDLE; tx_active<=0 unless IDLE immediately accepts a new bit.
- Boundary conditions:
  - bit_valid asserted during STUFF or EOP: ignored (stalled), then accepted normally.
  - A new packet may start in the cycle right after EOP_J.
  - A one-bit packet is legal.
  - Zero-length pulses of bit_valid cannot occur because IDLE consumes immediately.
- No internal FIFO: throughput is one bit per cycle, minus stall cycles.

Optional Feature:
- Macro: USB_LOW_SPEED_EN.
- Defined: low-speed polarity. J = dp=0, dm=1; K = dp=1, dm=0; reset/idle drives dp=0, dm=1. SE0 and NRZI/stuffing are unchanged.
- Undefined: full-speed polarity as specified above.

Test Plan:
- SYNC 0,0,0,0,0,0,0,1 from IDLE, then bit_valid low:
  - dp/dm cycles 1-8: K,J,K,J,K,J,K,K.
  - Then SE0,SE0,J with eop_done=1 on the J cycle.
  - tx_active=1 for cycles 1-11, then 0.
- Eight consecutive 1s mid-packet (level J):
  - stall=1 for exactly one cycle after the 6th 1.
  - Line toggles to K for the stuff bit, then holds K for 1s #7 and #8.
  - bit_in is held and no bit is lost.
- Packet ending in exactly six 1s: stuff toggle appears on the line, then SE0,SE0,J. Total EOP delayed by one cycle.
- Assert rst_b=0 mid-packet during the SE0 phase:
  - dp=1, dm=0, tx_active=0, stall=0 immediately, without waiting for a clock edge.
  - The next packet encodes from level=1.
- bit_valid held high through EOP of packet A with a new bit pending:
  - stall=1 in EOP states.
  - The first bit of packet B is consumed in the IDLE cycle right after EOP_J and appears on the next cycle.
- USB_LOW_SPEED_EN defined, repeat the SYNC test:
  - Line sequence dp/dm = 1/0,0/1,1/0,... (mirrored), then SE0,SE0, then dp=0, dm=1.
